seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the board's active-low multiplexed 8-digit 7-segment display drive.
- Monitors an anode-select bus and a segment bus and recovers the BCD digit shown on each position.
- Reassembles the 8 digits into a 32-bit BCD word, with per-digit valid/error flags.
- Used for display loopback self-test and for capturing an external scanned display.

---
 rtl/seg7_scan_decoder.sv | 187 ++++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// Recovers the BCD digits shown on an active-low, multiplexed 8-digit 7-segment display
// and republishes them as a double-buffered 32-bit word with per-digit valid/error flags.
module seg7_scan_decoder #(
   parameter int unsigned STABLE_CYCLES = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  an_in,
   input  logic [6:0]  seg_in,
   output logic [31:0] bcd_out,
   output logic [7:0]  digit_valid,
   output logic [7:0]  digit_err,
   output logic        frame_valid,
   output logic        frame_err
);

   localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      TRACK,
      LOCKED
   } state_t;

   logic [7:0]  an_m;
   logic [7:0]  an_s;
   logic [6:0]  seg_m;
   logic [6:0]  seg_s;
   logic [7:0]  cnt;
   logic        fresh;
   state_t      state;
   state_t      state_next;
   logic        capture;
   logic        one_hot;
   logic [2:0]  idx;
   logic [3:0]  dec_nib;
   logic        dec_valid;
   logic        dec_err;
   logic [31:0] shadow_bcd;
   logic [7:0]  shadow_valid;
   logic [7:0]  shadow_err;
   logic [7:0]  seen;
   logic [7:0]  seen_next;
   logic        publish_pend;

   function automatic logic one_hot_low(input logic [7:0] an);
      logic [3:0] zeros;
      zeros = '0;
      for (int i = 0; i < 8; i++) begin
         zeros = zeros + {3'b000, ~an[i]};
      end
      return zeros == 4'd1;
   endfunction

   // The counter is updated on the same edge that loads an_s, so its value always
   // describes how long the current synchronized sample has already been held.
   always_ff @(posedge clk) begin
      if (reset) begin
         an_m  <= '1;
         an_s  <= '1;
         seg_m <= '1;
         seg_s <= '1;
         cnt   <= '0;
         fresh <= 1'b0;
      end else begin
         an_m  <= an_in;
         an_s  <= an_m;
         seg_m <= seg_in;
         seg_s <= seg_m;
         if ({an_m, seg_m} != {an_s, seg_s}) begin
            cnt   <= '0;
            fresh <= 1'b1;
         end else begin
            fresh <= 1'b0;
            if (cnt != CNT_MAX) begin
               cnt <= cnt + 8'd1;
            end
         end
      end
   end

   always_comb begin
      one_hot = one_hot_low(an_s);
      idx     = '0;
      for (int i = 0; i < 8; i++) begin
         if (!an_s[i]) begin
            idx = 3'(i);
         end
      end
   end

   always_comb begin
      dec_nib   = 4'hF;
      dec_valid = 1'b0;
      dec_err   = 1'b0;
      case (seg_s)
         7'h40: begin dec_nib = 4'd0; dec_valid = 1'b1; end
         7'h79: begin dec_nib = 4'd1; dec_valid = 1'b1; end
         7'h24: begin dec_nib = 4'd2; dec_valid = 1'b1; end
         7'h30: begin dec_nib = 4'd3; dec_valid = 1'b1; end
         7'h19: begin dec_nib = 4'd4; dec_valid = 1'b1; end
         7'h12: begin dec_nib = 4'd5; dec_valid = 1'b1; end
         7'h02: begin dec_nib = 4'd6; dec_valid = 1'b1; end
         7'h78: begin dec_nib = 4'd7; dec_valid = 1'b1; end
         7'h00: begin dec_nib = 4'd8; dec_valid = 1'b1; end
         7'h10: begin dec_nib = 4'd9; dec_valid = 1'b1; end
         7'h7F: dec_err = 1'b0;
         default: dec_err = 1'b1;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (one_hot) begin
               state_next = TRACK;
            end
         end
         TRACK: begin
            if (!one_hot) begin
               state_next = IDLE;
            end else if (cnt == CNT_MAX) begin
               capture    = 1'b1;
               state_next = LOCKED;
            end
         end
         LOCKED: begin
            if (!one_hot) begin
               state_next = IDLE;
            end else if (fresh) begin
               state_next = TRACK;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // A publish clears the seen mask before a same-cycle capture marks its digit,
   // so that capture starts the next frame instead of being lost.
   always_comb begin
      seen_next = publish_pend ? 8'h00 : seen;
      if (capture) begin
         seen_next[idx] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         shadow_bcd   <= '1;
         shadow_valid <= '0;
         shadow_err   <= '0;
         seen         <= '0;
         publish_pend <= 1'b0;
         bcd_out      <= '1;
         digit_valid  <= '0;
         digit_err    <= '0;
         frame_valid  <= 1'b0;
         frame_err    <= 1'b0;
      end else begin
         seen         <= seen_next;
         publish_pend <= capture && (seen_next == 8'hFF);
         frame_valid  <= publish_pend;
         if (publish_pend) begin
            bcd_out     <= shadow_bcd;
            digit_valid <= shadow_valid;
            digit_err   <= shadow_err;
            frame_err   <= |shadow_err;
         end
         if (capture) begin
            shadow_bcd[{idx, 2'b00} +: 4] <= dec_nib;
            shadow_valid[idx]             <= dec_valid;
            shadow_err[idx]               <= dec_err;
         end
      end
   end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Self-checking bench for seg7_scan_decoder: fixed scan vectors, hand-written corner sequences
// and random scanning, all compared every cycle against a run-length reference model.
module tb_seg7_scan_decoder;

   localparam int STABLE = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  an_in;
   logic [6:0]  seg_in;
   logic [31:0] bcd_out;
   logic [7:0]  digit_valid;
   logic [7:0]  digit_err;
   logic        frame_valid;
   logic        frame_err;

   int asserts = 0;
   int fails   = 0;
   int dut_frames = 0;

   logic [6:0] seg_code [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   typedef struct {
      logic [55:0] segs;
      logic [31:0] bcd;
      logic [7:0]  valid;
      logic [7:0]  err;
      logic        ferr;
   } scan_vec_t;

   scan_vec_t vecs [4];

   always #5 clk = ~clk;

   seg7_scan_decoder #(.STABLE_CYCLES(STABLE)) dut (
      .clk        (clk),
      .reset      (reset),
      .an_in      (an_in),
      .seg_in     (seg_in),
      .bcd_out    (bcd_out),
      .digit_valid(digit_valid),
      .digit_err  (digit_err),
      .frame_valid(frame_valid),
      .frame_err  (frame_err)
   );

   // Reference model: a capture happens on the STABLE-th cycle of any run of identical
   // synchronized samples whose anode bus has exactly one low bit; publish one cycle later.
   bit          model_ready = 1'b0;
   logic [14:0] sync_d1, sync_d2, last_s;
   int          run_len;
   logic [3:0]  m_nib [8];
   logic [7:0]  m_valid, m_err, m_seen;
   bit          m_pend;
   logic [31:0] exp_bcd;
   logic [7:0]  exp_valid, exp_err;
   logic        exp_fv, exp_ferr;
   int          exp_frames = 0;

   task automatic ref_decode(input logic [6:0] seg, output logic [3:0] nib,
                             output logic v, output logic e);
      int digit;
      digit = -1;
      for (int d = 0; d < 10; d++) begin
         if (seg == seg_code[d]) digit = d;
      end
      if (digit >= 0) begin
         nib = 4'(digit); v = 1'b1; e = 1'b0;
      end else begin
         nib = 4'hF; v = 1'b0; e = (seg != 7'h7F);
      end
   endtask

   task automatic model_step();
      logic [14:0] cur;
      int          pos;
      logic [3:0]  nib;
      logic        v, e;
      if (reset) begin
         sync_d1 = '1; sync_d2 = '1; last_s = '1; run_len = 0;
         for (int i = 0; i < 8; i++) m_nib[i] = 4'hF;
         m_valid = '0; m_err = '0; m_seen = '0; m_pend = 1'b0;
         exp_bcd = '1; exp_valid = '0; exp_err = '0; exp_fv = 1'b0; exp_ferr = 1'b0;
         model_ready = 1'b1;
      end else if (model_ready) begin
         cur = sync_d2;
         if (cur == last_s) run_len++;
         else begin
            run_len = 1;
            last_s  = cur;
         end
         exp_fv = 1'b0;
         if (m_pend) begin
            for (int i = 0; i < 8; i++) exp_bcd[i*4 +: 4] = m_nib[i];
            exp_valid = m_valid;
            exp_err   = m_err;
            exp_ferr  = (m_err != 8'h00);
            exp_fv    = 1'b1;
            exp_frames++;
            m_seen = '0;
            m_pend = 1'b0;
         end
         if (run_len == STABLE && $countones(~cur[14:7]) == 1) begin
            pos = 0;
            for (int i = 0; i < 8; i++) if (!cur[7+i]) pos = i;
            ref_decode(cur[6:0], nib, v, e);
            m_nib[pos] = nib; m_valid[pos] = v; m_err[pos] = e; m_seen[pos] = 1'b1;
            if (m_seen == 8'hFF) m_pend = 1'b1;
         end
         sync_d2 = sync_d1;
         sync_d1 = {an_in, seg_in};
      end
   endtask

   task automatic checkOutput(input string name, input logic [63:0] actual,
                              input logic [63:0] expected);
      asserts++;
      if (actual !== expected) begin
         fails++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] an, input logic [6:0] seg, input int cycles);
      an_in  = an;
      seg_in = seg;
      repeat (cycles) @(negedge clk);
   endtask

   task automatic show_digit(input int d, input logic [6:0] seg, input int hold);
      applyStimulus(~(8'h01 << d), seg, hold);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      applyStimulus(8'hFF, 7'h7F, 2);
      reset = 1'b0;
   endtask

   task automatic check_reset_state(input string name);
      checkOutput(name, {14'd0, bcd_out, digit_valid, digit_err, frame_valid, frame_err},
                  {14'd0, 32'hFFFF_FFFF, 8'h00, 8'h00, 1'b0, 1'b0});
   endtask

   initial begin
      @(posedge clk);
      forever begin
         model_step();
         @(posedge clk);
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (model_ready) begin
            checkOutput("model_outputs",
                        {14'd0, bcd_out, digit_valid, digit_err, frame_valid, frame_err},
                        {14'd0, exp_bcd, exp_valid, exp_err, exp_fv, exp_ferr});
            if (frame_valid === 1'b1) dut_frames++;
         end
      end
   end

   initial begin
      int f0;
      logic [55:0] segs;
      reset  = 1'b1;
      an_in  = 8'hFF;
      seg_in = 7'h7F;
      @(negedge clk);
      do_reset();
      check_reset_state("reset_values");

      vecs[0] = '{{7'h00, 7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79},
                  32'h8765_4321, 8'hFF, 8'h00, 1'b0};
      vecs[1] = '{{7'h10, 7'h10, 7'h7E, 7'h10, 7'h7F, 7'h10, 7'h10, 7'h10},
                  32'h99F9_F999, 8'hD7, 8'h20, 1'b1};
      vecs[2] = '{{7'h19, 7'h24, 7'h78, 7'h12, 7'h30, 7'h02, 7'h10, 7'h40},
                  32'h4275_3690, 8'hFF, 8'h00, 1'b0};
      vecs[3] = '{{8{7'h7F}}, 32'hFFFF_FFFF, 8'h00, 8'h00, 1'b0};

      for (int v = 0; v < 4; v++) begin
         f0 = dut_frames;
         for (int d = 0; d < 8; d++) begin
            show_digit(d, vecs[v].segs[d*7 +: 7], 10);
            applyStimulus(8'hFF, 7'h7F, 2);
         end
         applyStimulus(8'hFF, 7'h7F, 6);
         checkOutput($sformatf("vec%0d_frames", v), 64'(dut_frames), 64'(f0 + 1));
         checkOutput($sformatf("vec%0d_bcd", v), 64'(bcd_out), 64'(vecs[v].bcd));
         checkOutput($sformatf("vec%0d_valid", v), 64'(digit_valid), 64'(vecs[v].valid));
         checkOutput($sformatf("vec%0d_err", v), 64'(digit_err), 64'(vecs[v].err));
         checkOutput($sformatf("vec%0d_ferr", v), 64'(frame_err), 64'(vecs[v].ferr));
      end

      // Too-short hold and a two-digits-low glitch must not capture digit 0.
      do_reset();
      f0 = dut_frames;
      applyStimulus(8'hFE, 7'h79, 3);
      applyStimulus(8'hFF, 7'h7F, 4);
      applyStimulus(8'hFC, 7'h79, 20);
      applyStimulus(8'hFF, 7'h7F, 4);
      for (int d = 1; d < 8; d++) begin
         show_digit(d, seg_code[d], 8);
         applyStimulus(8'hFF, 7'h7F, 3);
      end
      applyStimulus(8'hFF, 7'h7F, 8);
      checkOutput("short_hold_no_frame", 64'(dut_frames), 64'(f0));
      show_digit(0, 7'h79, 4);
      applyStimulus(8'hFF, 7'h7F, 8);
      checkOutput("min_hold_frame", 64'(dut_frames), 64'(f0 + 1));
      checkOutput("min_hold_bcd", 64'(bcd_out), 64'h7654_3211);

      // Digit 2 shown twice in one frame: the later value wins.
      f0 = dut_frames;
      show_digit(2, 7'h19, 8);
      for (int d = 0; d < 7; d++) begin
         if (d != 2) show_digit(d, 7'h00, 8);
      end
      show_digit(2, 7'h02, 8);
      show_digit(7, 7'h00, 8);
      applyStimulus(8'hFF, 7'h7F, 6);
      checkOutput("overwrite_frames", 64'(dut_frames), 64'(f0 + 1));
      checkOutput("overwrite_bcd", 64'(bcd_out), 64'h8888_8688);
      for (int d = 0; d < 8; d++) show_digit(d, 7'h30, 7);
      applyStimulus(8'hFF, 7'h7F, 6);
      checkOutput("second_scan_frames", 64'(dut_frames), 64'(f0 + 2));
      checkOutput("second_scan_bcd", 64'(bcd_out), 64'h3333_3333);

      // Reset after a partial frame discards the already-seen digits.
      for (int d = 0; d < 5; d++) show_digit(d, 7'h12, 8);
      do_reset();
      check_reset_state("mid_frame_reset");
      f0 = dut_frames;
      for (int d = 5; d < 8; d++) show_digit(d, 7'h78, 8);
      for (int d = 0; d < 4; d++) show_digit(d, 7'h10, 8);
      applyStimulus(8'hFF, 7'h7F, 8);
      checkOutput("no_stale_frame", 64'(dut_frames), 64'(f0));
      show_digit(4, 7'h40, 8);
      applyStimulus(8'hFF, 7'h7F, 6);
      checkOutput("post_reset_frames", 64'(dut_frames), 64'(f0 + 1));
      checkOutput("post_reset_bcd", 64'(bcd_out), 64'h7770_9999);

      // Random scanning with glitches, blanks and unknown patterns.
      for (int r = 0; r < 30; r++) begin
         for (int k = 0; k < 12; k++) begin
            case ($urandom_range(3))
               0: applyStimulus(8'($urandom), 7'($urandom), $urandom_range(1, 3));
               1: show_digit($urandom_range(7), 7'($urandom), $urandom_range(1, 8));
               2: applyStimulus(8'hFF, 7'h7F, $urandom_range(1, 3));
               default: show_digit($urandom_range(7), seg_code[$urandom_range(9)],
                                   $urandom_range(2, 8));
            endcase
         end
         for (int d = 0; d < 8; d++) begin
            segs[d*7 +: 7] = ($urandom_range(5) == 0) ? 7'h7F : seg_code[$urandom_range(9)];
            show_digit(d, segs[d*7 +: 7], $urandom_range(4, 7));
         end
      end
      applyStimulus(8'hFF, 7'h7F, 10);
      checkOutput("frame_total", 64'(dut_frames), 64'(exp_frames));

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
      $finish;
   end

endmodule
